// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// the stall bus type and default parameter values.
package stall_ctrl_pkg;

   localparam int STG_PC  = 0;
   localparam int STG_IF  = 1;
   localparam int STG_ID  = 2;
   localparam int STG_EX  = 3;
   localparam int STG_MEM = 4;
   localparam int STG_WB  = 5;

   localparam int NSTAGE_DEFAULT  = STG_WB + 1;
   localparam int CNT_W_DEFAULT   = 32;
   localparam int TIMEOUT_DEFAULT = 1024;

   typedef logic [NSTAGE_DEFAULT-1:0] StallBus;

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; used for the stall and
// flush performance counters.
module sat_counter
   import stall_ctrl_pkg::*;
#(
   parameter int W = CNT_W_DEFAULT
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: merges stall requests, the global ready pause and
// flush requests (with deferral) into per-stage stall/bubble/flush controls.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int NSTAGE  = NSTAGE_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic [NSTAGE-1:0]         stall_req,
   input  logic                      flush_req,
   input  logic [$clog2(NSTAGE)-1:0] flush_stage,
   output logic [NSTAGE-1:0]         stall_o,
   output logic [NSTAGE-1:0]         bubble_o,
   output logic [NSTAGE-1:0]         flush_o,
   output logic                      hang_o,
   output logic [CNT_W-1:0]          stall_cycles_o,
   output logic [CNT_W-1:0]          flush_cnt_o
);

   localparam int KW   = $clog2(NSTAGE);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic              pendV_q, pendV_d;
   logic [KW-1:0]     pendK_q, pendK_d;
   logic [WD_W-1:0]   wdCnt_q, wdCnt_d;
   logic              hang_q, hang_d;

   logic [NSTAGE-1:0] baseStall;
   logic [NSTAGE-1:0] youngMask;
   logic [NSTAGE-1:0] stallMasked;
   logic [NSTAGE-1:0] maskedReq;
   logic              liveV;
   logic              candV;
   logic [KW-1:0]     candK;
   logic              apply;

   // A request stalls its own stage and everything younger; accumulate from the oldest stage down.
   always_comb begin
      logic acc;
      acc = ~rdy;
      for (int i = NSTAGE - 1; i >= 0; i--) begin
         acc          = acc | stall_req[i];
         baseStall[i] = acc;
      end
   end

   // Index 0 has nothing younger to kill, so it never becomes a candidate; the older candidate wins.
   always_comb begin
      liveV = flush_req && (flush_stage != '0) && (int'(flush_stage) < NSTAGE);
      candV = liveV | pendV_q;
      candK = pendK_q;
      if (liveV && (!pendV_q || (flush_stage > pendK_q))) begin
         candK = flush_stage;
      end
      apply = candV && rdy && !baseStall[candK];
      for (int i = 0; i < NSTAGE; i++) begin
         youngMask[i] = apply && (i < int'(candK));
      end
   end

   always_comb begin
      stallMasked = baseStall & ~youngMask;
      maskedReq   = stall_req & ~youngMask;
      stall_o     = '0;
      bubble_o    = '0;
      flush_o     = '0;
      if (!rst) begin
         stall_o = stallMasked;
         flush_o = youngMask;
         for (int i = 0; i < NSTAGE - 1; i++) begin
            bubble_o[i] = stallMasked[i] & ~stallMasked[i+1];
         end
      end
   end

   // Blocked flushes are held until stage k can advance; ready low freezes the watchdog.
   always_comb begin
      pendV_d = pendV_q;
      pendK_d = pendK_q;
      wdCnt_d = wdCnt_q;
      hang_d  = hang_q;
      if (rst) begin
         pendV_d = 1'b0;
         pendK_d = '0;
         wdCnt_d = '0;
         hang_d  = 1'b0;
      end else begin
         if (apply) begin
            pendV_d = 1'b0;
            pendK_d = '0;
         end else if (candV) begin
            pendV_d = 1'b1;
            pendK_d = candK;
         end
         if (rdy) begin
            if (|stall_req) begin
               if (wdCnt_q != WD_W'(TIMEOUT)) begin
                  wdCnt_d = wdCnt_q + WD_W'(1);
               end
            end else begin
               wdCnt_d = '0;
            end
         end
         if (wdCnt_d == WD_W'(TIMEOUT)) begin
            hang_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      pendV_q <= pendV_d;
      pendK_q <= pendK_d;
      wdCnt_q <= wdCnt_d;
      hang_q  <= hang_d;
   end

   assign hang_o = hang_q;

   sat_counter #(.W(CNT_W)) u_stallCnt (
      .clk     (clk),
      .clr     (rst),
      .inc     (!rst && rdy && (|maskedReq)),
      .count_o (stall_cycles_o)
   );

   sat_counter #(.W(CNT_W)) u_flushCnt (
      .clk     (clk),
      .clr     (rst),
      .inc     (!rst && apply),
      .count_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: a behavioural model pushes expected
// outputs per cycle to a scoreboard that is popped and compared mid-cycle.
module tb_stall_ctrl;
   import stall_ctrl_pkg::*;

   localparam int NS = 6;
   localparam int CW = 6;
   localparam int TO = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rdy = 1'b1;
   logic [NS-1:0] stall_req = '0;
   logic          flush_req = 1'b0;
   logic [2:0]    flush_stage = '0;
   logic [NS-1:0] stall_o, bubble_o, flush_o;
   logic          hang_o;
   logic [CW-1:0] stall_cycles_o, flush_cnt_o;

   stall_ctrl #(.NSTAGE(NS), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .stall_req      (stall_req),
      .flush_req      (flush_req),
      .flush_stage    (flush_stage),
      .stall_o        (stall_o),
      .bubble_o       (bubble_o),
      .flush_o        (flush_o),
      .hang_o         (hang_o),
      .stall_cycles_o (stall_cycles_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NS-1:0] st;
      logic [NS-1:0] bu;
      logic [NS-1:0] fl;
      logic          hang;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   bit mPendV = 1'b0;
   int mPendK = 0;
   int mWd    = 0;
   bit mHang  = 1'b0;
   int mSc    = 0;
   int mFc    = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
         $error("[TB] check %s did not match", tag);
      end
   endtask

   // Pops the oldest expectation and compares every output against it.
   task automatic checkOutput();
      exp_t e;
      if (sbq.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sbq.pop_front();
      checkVal("stall", stall_o, e.st);
      checkVal("bubble", bubble_o, e.bu);
      checkVal("flush", flush_o, e.fl);
      checkVal("hang", hang_o, e.hang);
      checkVal("stall_cycles", stall_cycles_o, e.sc);
      checkVal("flush_cnt", flush_cnt_o, e.fc);
   endtask

   // Drives one cycle of inputs, predicts the outputs and the next model state.
   task automatic applyStimulus(input bit r, input bit rd, input logic [NS-1:0] req,
                                input bit fr, input logic [2:0] fk);
      exp_t          e;
      bit            base [NS];
      bit            s;
      bit            app;
      int            k, pk, lk;
      logic [NS-1:0] mreq;
      @(posedge clk);
      #1;
      rst         = r;
      rdy         = rd;
      stall_req   = req;
      flush_req   = fr;
      flush_stage = fk;

      s = !rd;
      for (int j = NS - 1; j >= 0; j--) begin
         s       = s | req[j];
         base[j] = s;
      end
      pk  = mPendV ? mPendK : 0;
      lk  = (fr && (int'(fk) < NS)) ? int'(fk) : 0;
      k   = (lk > pk) ? lk : pk;
      app = (k != 0) && rd && !base[k];

      e = '0;
      for (int i = 0; i < NS; i++) begin
         if (app && (i < k)) e.fl[i] = 1'b1;
         else                e.st[i] = base[i];
      end
      for (int i = 0; i < NS - 1; i++) begin
         e.bu[i] = e.st[i] && !e.st[i+1];
      end
      if (r) begin
         e.st = '0;
         e.bu = '0;
         e.fl = '0;
      end
      e.hang = mHang;
      e.sc   = CW'(mSc);
      e.fc   = CW'(mFc);
      sbq.push_back(e);

      if (r) begin
         mPendV = 1'b0;
         mPendK = 0;
         mWd    = 0;
         mHang  = 1'b0;
         mSc    = 0;
         mFc    = 0;
      end else begin
         if (rd) begin
            mreq = req;
            if (app) begin
               for (int i = 0; i < k; i++) mreq[i] = 1'b0;
            end
            if ((mreq != 0) && (mSc < CMAX)) mSc++;
            if (req != 0) begin
               if (mWd < TO) mWd++;
            end else begin
               mWd = 0;
            end
            if (mWd == TO) mHang = 1'b1;
         end
         if (app) begin
            mPendV = 1'b0;
            mPendK = 0;
            if (mFc < CMAX) mFc++;
         end else if (k != 0) begin
            mPendV = 1'b1;
            mPendK = k;
         end
      end

      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      repeat (2) @(posedge clk);

      // Reset forces all combinational controls low regardless of inputs.
      applyStimulus(1, 1, 6'b101010, 1, 3'd3);
      checkVal("rst_stall", stall_o, 6'b000000);

      // Single stall request at stage 2.
      applyStimulus(0, 1, 6'b000100, 0, 3'd0);
      checkVal("single_stall", stall_o, 6'b000111);
      checkVal("single_bubble", bubble_o, 6'b000100);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("single_cnt", stall_cycles_o, 1);

      // Global pause holds everything and leaves counters alone.
      applyStimulus(0, 0, 6'b000000, 0, 3'd0);
      checkVal("pause_stall", stall_o, 6'b111111);
      checkVal("pause_bubble", bubble_o, 6'b000000);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("pause_cnt", stall_cycles_o, 1);

      // Deferred flush: k=3 blocked by a stage-4 stall for three cycles.
      applyStimulus(0, 1, 6'b010000, 1, 3'd3);
      checkVal("defer_c0", flush_o, 6'b000000);
      applyStimulus(0, 1, 6'b010000, 0, 3'd0);
      applyStimulus(0, 1, 6'b010000, 0, 3'd0);
      checkVal("defer_c2", flush_o, 6'b000000);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("defer_c3", flush_o, 6'b000111);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("defer_cnt", flush_cnt_o, 1);

      // Merge: pending k=2 plus a live k=4 in the apply cycle.
      applyStimulus(0, 1, 6'b001000, 1, 3'd2);
      applyStimulus(0, 1, 6'b000000, 1, 3'd4);
      checkVal("merge_flush", flush_o, 6'b001111);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("merge_cnt", flush_cnt_o, 2);

      // Wrong-path stall request under an applying flush is ignored.
      applyStimulus(0, 1, 6'b000010, 1, 3'd3);
      checkVal("wrongpath_stall", stall_o, 6'b000000);
      checkVal("wrongpath_flush", flush_o, 6'b000111);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);

      // Requests are latched while paused; a smaller k does not replace a larger one.
      applyStimulus(0, 0, 6'b000000, 1, 3'd2);
      applyStimulus(0, 0, 6'b000000, 1, 3'd1);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("latch_flush", flush_o, 6'b000011);

      // Two 7-cycle stalls separated by a gap never trip the watchdog.
      for (int n = 0; n < 7; n++) applyStimulus(0, 1, 6'b000010, 0, 3'd0);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      for (int n = 0; n < 7; n++) applyStimulus(0, 1, 6'b000010, 0, 3'd0);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("wd_short", hang_o, 1'b0);

      // Eight consecutive stalled cycles set the sticky hang flag.
      for (int n = 0; n < 8; n++) applyStimulus(0, 1, 6'b000010, 0, 3'd0);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("wd_hang", hang_o, 1'b1);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("wd_sticky", hang_o, 1'b1);

      // Reset with a pending flush discards it.
      applyStimulus(0, 1, 6'b100000, 1, 3'd3);
      applyStimulus(1, 1, 6'b100000, 1, 3'd3);
      checkVal("rstmid_flush", flush_o, 6'b000000);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("post_rst_flush", flush_o, 6'b000000);
      checkVal("post_rst_hang", hang_o, 1'b0);
      checkVal("post_rst_fc", flush_cnt_o, 0);

      // Pause freezes the watchdog count: 5 + 3 stalled cycles around it reach the limit.
      for (int n = 0; n < 5; n++) applyStimulus(0, 1, 6'b000010, 0, 3'd0);
      applyStimulus(0, 0, 6'b000010, 0, 3'd0);
      applyStimulus(0, 0, 6'b000010, 0, 3'd0);
      for (int n = 0; n < 3; n++) applyStimulus(0, 1, 6'b000010, 0, 3'd0);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("wd_freeze", hang_o, 1'b1);

      // Stall counter saturates at all-ones.
      for (int n = 0; n < 70; n++) applyStimulus(0, 1, 6'b001000, 0, 3'd0);
      applyStimulus(0, 1, 6'b000000, 0, 3'd0);
      checkVal("sc_saturate", stall_cycles_o, CMAX);

      checkVal("sb_drained", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
